// File: rtl/alu_sequencer.sv
// alu_sequencer
// Request/response controller for the byte-serial 32-bit ALU. It accepts one
// operation (6-bit opcode plus two 32-bit operands) per req handshake. It then
// streams the operand bytes least-significant first, loads the opcode and runs
// the two execute phases. The 32-bit result and carry flag are returned on a
// valid/ready response channel.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   req_valid/req_ready        request handshake
//   req_op[5:0]                opcode
//   req_a[31:0], req_b[31:0]   operands
//   rsp_valid/rsp_ready        response handshake
//   rsp_result[31:0]           assembled result
//   rsp_carry                  ALU carry flag for this operation
//   rsp_err                    illegal opcode, ALU not started
//   alu_a[7:0], alu_b[7:0]     ALU byte inputs (alu_b = {2'b00, op} in OPLD)
//   alu_ld, alu_opld, alu_exe  ALU strobes (at most one high per cycle)
//   alu_out                    ALU half select (0 = low, 1 = high)
//   alu_res[15:0], alu_carry   ALU result half and carry flag
module alu_sequencer #(
  parameter int OP_MAX = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_carry,
  output logic        rsp_err,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic        alu_ld,
  output logic        alu_opld,
  output logic        alu_exe,
  output logic        alu_out,
  input  logic [15:0] alu_res,
  input  logic        alu_carry
);

  localparam logic [5:0] OP_MAX_C = 6'(OP_MAX);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_LOAD0  = 4'd1,
    S_LOAD1  = 4'd2,
    S_LOAD2  = 4'd3,
    S_LOAD3  = 4'd4,
    S_OPLD   = 4'd5,
    S_EXE_LO = 4'd6,
    S_EXE_HI = 4'd7,
    S_CAPT   = 4'd8,
    S_RESP   = 4'd9,
    S_FLUSH  = 4'd10
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] result_q, result_d;
  logic        carry_q, carry_d;
  logic        err_q, err_d;
  // Mirrors the ALU's free-running modulo-4 byte counter. The ALU counter is
  // never reset, so this one must survive rst as well; it starts at zero at
  // power-up to match the ALU.
  logic [1:0]  ld_phase_q = 2'd0;
  logic [1:0]  ld_phase_d;

  logic        req_fire_s;
  logic        op_illegal_s;

  assign req_fire_s   = req_valid && req_ready;
  assign op_illegal_s = (req_op > OP_MAX_C);

  // State register: rst forces FLUSH so the byte counter is realigned first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FLUSH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_fire_s) begin
          state_d = op_illegal_s ? S_RESP : S_LOAD0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD0:  state_d = S_LOAD1;
      S_LOAD1:  state_d = S_LOAD2;
      S_LOAD2:  state_d = S_LOAD3;
      S_LOAD3:  state_d = S_OPLD;
      S_OPLD:   state_d = S_EXE_LO;
      S_EXE_LO: state_d = S_EXE_HI;
      S_EXE_HI: state_d = S_CAPT;
      S_CAPT:   state_d = S_RESP;
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      S_FLUSH: begin
        // Phase 3 issues its last pulse this cycle and wraps to 0.
        if ((ld_phase_q == 2'd0) || (ld_phase_q == 2'd3)) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_FLUSH;
        end
      end
      default: state_d = S_FLUSH;
    endcase
  end

  // Output decode; rst gates every strobe so none reach the ALU during reset.
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    alu_a     = 8'd0;
    alu_b     = 8'd0;
    alu_ld    = 1'b0;
    alu_opld  = 1'b0;
    alu_exe   = 1'b0;
    alu_out   = 1'b0;
    if (!rst) begin
      case (state_q)
        S_IDLE: req_ready = 1'b1;
        S_LOAD0: begin
          alu_ld = 1'b1;
          alu_a  = a_q[7:0];
          alu_b  = b_q[7:0];
        end
        S_LOAD1: begin
          alu_ld = 1'b1;
          alu_a  = a_q[15:8];
          alu_b  = b_q[15:8];
        end
        S_LOAD2: begin
          alu_ld = 1'b1;
          alu_a  = a_q[23:16];
          alu_b  = b_q[23:16];
        end
        S_LOAD3: begin
          alu_ld = 1'b1;
          alu_a  = a_q[31:24];
          alu_b  = b_q[31:24];
        end
        S_OPLD: begin
          alu_opld = 1'b1;
          alu_b    = {2'b00, op_q};
        end
        S_EXE_LO: begin
          alu_exe = 1'b1;
          alu_out = 1'b0;
        end
        S_EXE_HI: begin
          alu_exe = 1'b1;
          alu_out = 1'b1;
        end
        S_RESP:  rsp_valid = 1'b1;
        S_FLUSH: alu_ld = (ld_phase_q != 2'd0);
        default: begin
          req_ready = 1'b0;
          rsp_valid = 1'b0;
        end
      endcase
    end else begin
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      alu_ld    = 1'b0;
      alu_opld  = 1'b0;
      alu_exe   = 1'b0;
    end
  end

  // Request capture and result assembly.
  always_comb begin
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    carry_d  = carry_q;
    err_d    = err_q;
    if (req_fire_s) begin
      op_d     = req_op;
      a_d      = req_a;
      b_d      = req_b;
      result_d = 32'd0;
      carry_d  = 1'b0;
      err_d    = op_illegal_s;
    end else begin
      case (state_q)
        // The ALU presents each half one cycle after the matching execute.
        S_EXE_HI: result_d[15:0] = alu_res;
        S_CAPT: begin
          result_d[31:16] = alu_res;
          carry_d         = alu_carry;
          err_d           = 1'b0;
        end
        default: result_d = result_q;
      endcase
    end
  end

  // Byte-phase tracker follows every ld pulse actually issued.
  always_comb begin
    if (alu_ld) begin
      ld_phase_d = ld_phase_q + 2'd1;
    end else begin
      ld_phase_d = ld_phase_q;
    end
  end

  // Operand and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= 6'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      result_q <= 32'd0;
      carry_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      err_q    <= err_d;
    end
  end

  // Byte-phase register, deliberately untouched by rst.
  always_ff @(posedge clk) begin
    ld_phase_q <= ld_phase_d;
  end

  assign rsp_result = result_q;
  assign rsp_carry  = carry_q;
  assign rsp_err    = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_carry;
  logic        rsp_err;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic        alu_ld;
  logic        alu_opld;
  logic        alu_exe;
  logic        alu_out;
  logic [15:0] alu_res;
  logic        alu_carry;

  int n_cmp = 0;
  int n_bad = 0;

  alu_sequencer #(.OP_MAX(17)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ld(alu_ld), .alu_opld(alu_opld),
    .alu_exe(alu_exe), .alu_out(alu_out), .alu_res(alu_res), .alu_carry(alu_carry)
  );

  always #5 clk = ~clk;

  // Behavioural byte-serial ALU: free-running byte counter, one-cycle result latency.
  logic [1:0]  m_cnt = 2'd0;
  logic [31:0] m_a = 32'd0;
  logic [31:0] m_b = 32'd0;
  logic [5:0]  m_op = 6'd0;
  logic [15:0] m_res = 16'd0;
  logic        m_carry = 1'b0;
  logic [32:0] m_full;

  function automatic logic [32:0] alu_f(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [5:0] base;
    base = (op >= 6'd9) ? (op - 6'd9) : op;
    case (base)
      6'd0:    return {1'b0, a} + {1'b0, b};
      6'd1:    return {1'b0, a} - {1'b0, b};
      6'd2:    return {1'b0, a & b};
      6'd3:    return {1'b0, a | b};
      6'd4:    return {1'b0, a ^ b};
      6'd5:    return {1'b0, ~a};
      default: return 33'd0;
    endcase
  endfunction

  assign m_full    = alu_f(m_op, m_a, m_b);
  assign alu_res   = m_res;
  assign alu_carry = m_carry;

  always @(posedge clk) begin
    if (alu_ld) begin
      m_a[{m_cnt, 3'b000} +: 8] <= alu_a;
      m_b[{m_cnt, 3'b000} +: 8] <= alu_b;
      m_cnt <= m_cnt + 2'd1;
    end
    if (alu_opld) m_op <= alu_b[5:0];
    if (alu_exe) begin
      m_res   <= alu_out ? m_full[31:16] : m_full[15:0];
      m_carry <= m_full[32];
    end
  end

  // Strobe counters and exclusivity monitor.
  int n_ld = 0, n_opld = 0, n_exe = 0, n_excl = 0;
  always @(posedge clk) begin
    if (alu_ld)   n_ld   <= n_ld + 1;
    if (alu_opld) n_opld <= n_opld + 1;
    if (alu_exe)  n_exe  <= n_exe + 1;
    if ((int'(alu_ld) + int'(alu_opld) + int'(alu_exe)) > 1) n_excl <= n_excl + 1;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running want finished");
    $fatal(1, "timeout");
  end

  // Issue one request and wait (bounded) for rsp_valid; lat counts cycles after accept.
  task automatic do_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic rdy);
    @(negedge clk);
    rdy       = req_ready;
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    int k;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_carry, rsp_err} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 0000", {req_ready, rsp_valid, rsp_carry, rsp_err});
    end
    n_cmp++;
    if (rsp_result !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_result: got %h want 00000000", rsp_result);
    end
    n_cmp++;
    if ({alu_ld, alu_opld, alu_exe, alu_out, alu_a, alu_b} !== 20'd0) begin
      n_bad++;
      $display("FAIL reset_alu: got %h want 00000", {alu_ld, alu_opld, alu_exe, alu_out, alu_a, alu_b});
    end
    rst = 1'b0;
    k = 0;
    while (req_ready !== 1'b1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_add();
    int lat, s_ld, s_op, s_ex;
    logic rdy;
    s_ld = n_ld; s_op = n_opld; s_ex = n_exe;
    do_op(6'd0, 32'h12345678, 32'h11111111, lat, rdy);
    n_cmp++;
    if (rdy !== 1'b1) begin n_bad++; $display("FAIL add_ready: got %b want 1", rdy); end
    n_cmp++;
    if (lat !== 9) begin n_bad++; $display("FAIL add_latency: got %0d want 9", lat); end
    n_cmp++;
    if ({rsp_result, rsp_carry, rsp_err} !== {32'h23456789, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL add_result: got %h c%b e%b want 23456789 c0 e0", rsp_result, rsp_carry, rsp_err);
    end
    n_cmp++;
    if ((n_ld - s_ld) != 4 || (n_opld - s_op) != 1 || (n_exe - s_ex) != 2) begin
      n_bad++;
      $display("FAIL add_strobes: got ld=%0d opld=%0d exe=%0d want 4 1 2",
               n_ld - s_ld, n_opld - s_op, n_exe - s_ex);
    end
    n_cmp++;
    if (req_ready !== 1'b0) begin n_bad++; $display("FAIL add_busy: got %b want 0", req_ready); end
    finish_rsp();
    n_cmp++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL add_complete: got %b want 01", {rsp_valid, req_ready});
    end
  endtask

  task automatic test_carry_and_subi();
    int lat;
    logic rdy;
    do_op(6'd0, 32'hFFFFFFFF, 32'h00000001, lat, rdy);
    n_cmp++;
    if ({rsp_result, rsp_carry, rsp_err} !== {32'h00000000, 1'b1, 1'b0} || lat !== 9) begin
      n_bad++;
      $display("FAIL carry_add: got %h c%b e%b lat %0d want 00000000 c1 e0 lat 9",
               rsp_result, rsp_carry, rsp_err, lat);
    end
    finish_rsp();
    do_op(6'd10, 32'd5, 32'd3, lat, rdy);
    n_cmp++;
    if ({rsp_result, rsp_carry, rsp_err} !== {32'h00000002, 1'b0, 1'b0} || lat !== 9) begin
      n_bad++;
      $display("FAIL subi: got %h c%b e%b lat %0d want 00000002 c0 e0 lat 9",
               rsp_result, rsp_carry, rsp_err, lat);
    end
    finish_rsp();
  endtask

  task automatic test_illegal();
    int lat, s_all;
    logic rdy;
    s_all = n_ld + n_opld + n_exe;
    do_op(6'd20, 32'hDEADBEEF, 32'hCAFEF00D, lat, rdy);
    n_cmp++;
    if (lat !== 1) begin n_bad++; $display("FAIL illegal_latency: got %0d want 1", lat); end
    n_cmp++;
    if ({rsp_result, rsp_carry, rsp_err} !== {32'h00000000, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL illegal_rsp: got %h c%b e%b want 00000000 c0 e1", rsp_result, rsp_carry, rsp_err);
    end
    finish_rsp();
    n_cmp++;
    if ((n_ld + n_opld + n_exe - s_all) != 0) begin
      n_bad++;
      $display("FAIL illegal_strobes: got %0d want 0", n_ld + n_opld + n_exe - s_all);
    end
    do_op(6'd0, 32'd1, 32'd2, lat, rdy);
    n_cmp++;
    if ({rsp_result, rsp_err} !== {32'd3, 1'b0}) begin
      n_bad++;
      $display("FAIL after_illegal: got %h e%b want 00000003 e0", rsp_result, rsp_err);
    end
    finish_rsp();
  endtask

  task automatic test_backpressure();
    int lat, s_all;
    logic rdy;
    do_op(6'd5, 32'h0000FFFF, 32'h00000000, lat, rdy);
    s_all = n_ld + n_opld + n_exe;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({rsp_valid, req_ready, rsp_result} !== {1'b1, 1'b0, 32'hFFFF0000}) begin
        n_bad++;
        $display("FAIL hold_%0d: got v%b r%b %h want v1 r0 ffff0000", i, rsp_valid, req_ready, rsp_result);
      end
      @(negedge clk);
    end
    n_cmp++;
    if ((n_ld + n_opld + n_exe - s_all) != 0) begin
      n_bad++;
      $display("FAIL hold_strobes: got %0d want 0", n_ld + n_opld + n_exe - s_all);
    end
    finish_rsp();
    n_cmp++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL hold_release: got %b want 01", {rsp_valid, req_ready});
    end
  endtask

  task automatic test_reset_mid_op();
    int s_ld, s2, k, seen_rsp, lat;
    logic rdy;
    s_ld = n_ld;
    @(negedge clk);
    req_valid = 1'b1; req_op = 6'd0; req_a = 32'hAABBCCDD; req_b = 32'h11223344;
    @(negedge clk);              // LOAD0
    req_valid = 1'b0;
    @(negedge clk);              // LOAD1
    @(negedge clk);              // LOAD2 cycle: reset kills it
    rst = 1'b1;
    n_cmp++;
    if ((n_ld - s_ld) != 2) begin n_bad++; $display("FAIL mid_pre_ld: got %0d want 2", n_ld - s_ld); end
    s2 = n_ld;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    k = 0;
    seen_rsp = 0;
    while (req_ready !== 1'b1 && k < 10) begin
      if (rsp_valid === 1'b1) seen_rsp++;
      if (alu_ld === 1'b1) begin
        n_cmp++;
        if ({alu_a, alu_b} !== 16'd0) begin
          n_bad++;
          $display("FAIL flush_data: got %h want 0000", {alu_a, alu_b});
        end
      end
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if ((n_ld - s2) != 2 || k != 2) begin
      n_bad++;
      $display("FAIL flush_pulses: got %0d pulses %0d cycles want 2 2", n_ld - s2, k);
    end
    n_cmp++;
    if (seen_rsp != 0 || rsp_result !== 32'd0) begin
      n_bad++;
      $display("FAIL flush_no_rsp: got %0d rsp %h want 0 00000000", seen_rsp, rsp_result);
    end
    do_op(6'd4, 32'hF0F0F0F0, 32'hFFFF0000, lat, rdy);
    n_cmp++;
    if ({rsp_result, rsp_err} !== {32'h0F0FF0F0, 1'b0} || lat !== 9) begin
      n_bad++;
      $display("FAIL xor_after_flush: got %h e%b lat %0d want 0f0ff0f0 e0 lat 9", rsp_result, rsp_err, lat);
    end
    finish_rsp();
  endtask

  task automatic test_back_to_back();
    int acc, rsp;
    acc = 0;
    rsp = 0;
    @(negedge clk);
    req_valid = 1'b1; req_op = 6'd0; req_a = 32'd1; req_b = 32'd2;
    rsp_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (req_ready === 1'b1) acc++;
      if (rsp_valid === 1'b1) begin
        rsp++;
        n_cmp++;
        if (rsp_result !== 32'd3) begin
          n_bad++;
          $display("FAIL b2b_result_%0d: got %h want 00000003", rsp, rsp_result);
        end
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_cmp++;
    if (acc != 4 || rsp != 4) begin
      n_bad++;
      $display("FAIL b2b_rate: got %0d accepts %0d responses want 4 4", acc, rsp);
    end
  endtask

  task automatic test_exclusive();
    n_cmp++;
    if (n_excl != 0) begin
      n_bad++;
      $display("FAIL strobe_exclusive: got %0d overlaps want 0", n_excl);
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = 6'd0; req_a = 32'd0; req_b = 32'd0; rsp_ready = 1'b0;
    test_reset();
    test_add();
    test_carry_and_subi();
    test_illegal();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    test_exclusive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Request/response controller for the byte-serial 32-bit ALU (8-bit A/B byte inputs, `ld`/`opLd`/`exe`/`out` strobes, 16-bit `res`, `carryflag`). It accepts one complete operation per valid/ready handshake: 32-bit operands plus a 6-bit opcode. It then drives the ALU's load, opcode-load and two-phase execute sequence, reassembles the 32-bit result from the two 16-bit halves, and returns it on a valid/ready response channel. It sits between the instruction/issue logic and the ALU, and it is the only block that drives the ALU strobes.

## Interface
Parameters:
- `OP_MAX`, default 17: highest legal opcode. Legal opcodes are 0..17: ADD..SRL and ADDI..SRLI.

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request. High only in IDLE.
- `req_op`  in  6  opcode.
- `req_a`  in  32  operand A.
- `req_b`  in  32  operand B.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_result`  out  32  assembled result.
- `rsp_carry`  out  1  ALU carry flag captured for this operation.
- `rsp_err`  out  1  illegal opcode; the ALU was not started.
- `alu_a`  out  8  ALU A byte.
- `alu_b`  out  8  ALU B byte; carries `{2'b00, op}` during OPLD.
- `alu_ld`  out  1  ALU operand-byte load strobe.
- `alu_opld`  out  1  ALU opcode load strobe.
- `alu_exe`  out  1  ALU execute strobe.
- `alu_out`  out  1  ALU half select: 0 = low half, 1 = high half.
- `alu_res`  in  16  ALU result half.
- `alu_carry`  in  1  ALU carry flag.

## Operation
- **Request capture.** On `req_valid && req_ready`, latch op, A and B into internal registers.
- **Illegal opcode.** If `req_op > OP_MAX`, go to RESP with `rsp_err=1`, `rsp_result=0`, `rsp_carry=0`. No ALU strobes are issued.
- **FSM path:** IDLE → LOAD0 → LOAD1 → LOAD2 → LOAD3 → OPLD → EXE_LO → EXE_HI → CAPT → RESP → IDLE.
- **LOADk (k=0..3).**
  - `alu_ld=1`.
  - `alu_a=A[8k+7:8k]`, `alu_b=B[8k+7:8k]`.
  - Bytes are sent least-significant first.
- **OPLD.** `alu_opld=1`, `alu_b={2'b00,op}`, `alu_a=0`.
- **EXE_LO.** `alu_exe=1`, `alu_out=0`.
- **EXE_HI.**
  - `alu_exe=1`, `alu_out=1`.
  - Capture `alu_res` into `rsp_result[15:0]`. This is the low half, which is valid on `alu_res` during this cycle.
- **CAPT.**
  - Capture `alu_res` into `rsp_result[31:16]`.
  - Capture `alu_carry` into `rsp_carry`.
  - `rsp_err=0`.
- **RESP.**
  - `rsp_valid=1`.
  - Hold `rsp_result`, `rsp_carry` and `rsp_err` stable until `rsp_ready`, then go to IDLE.
- **Idle strobes.** Outside the states above, all `alu_*` outputs are 0.
- **Byte-phase tracker.**
  - The ALU's internal byte counter is modulo 4, advances on every `ld` pulse, and is never reset.
  - The controller mirrors it with a 2-bit `ld_phase` counter. `ld_phase` powers up at 0, increments on every `alu_ld` pulse it issues, and is **not** cleared by `rst`.
- **Reset.**
  - `rst` forces the FSM to FLUSH and clears the response registers.
  - FLUSH: if `ld_phase != 0`, assert `alu_ld=1` with `alu_a=alu_b=0` each cycle until `ld_phase` wraps to 0, then go to IDLE.
  - If `ld_phase == 0`, go straight to IDLE.
- **Width rules.**
  - Result is exactly 32 bits; no sign extension.
  - Opcode upper bits above 5 do not exist; `alu_b[7:6]` is always 0 in OPLD.

## Timing
- **Reset values while `rst` is high:**
  - `req_ready=0`, `rsp_valid=0`, `rsp_result=0`, `rsp_carry=0`, `rsp_err=0`.
  - All `alu_*` outputs 0.
- **After reset.** First cycle after `rst` deasserts: FLUSH (0-3 cycles), then IDLE with `req_ready=1`.
- **Legal-op latency.**
  - Handshake at edge 0 → LOAD0 in cycle 1 … CAPT in cycle 8.
  - `rsp_valid` first high in cycle 9: 9 cycles of latency.
  - Throughput: at best one op per 10 cycles.
- **Illegal-op latency.** `rsp_valid` high in cycle 1.
- **No overlap.** `req_ready=0` from the accept edge until the response handshake completes. No second request is queued.
- **Backpressure.** `rsp_ready` may be low for any number of cycles; outputs stay stable and no ALU strobes are issued.
- **Reset mid-operation.** Reset in any state takes priority. A partially sent operation is discarded and no response is produced for it.
- **Strobe exclusivity.** At most one of `alu_ld`, `alu_opld`, `alu_exe` is high in any cycle.

## Test plan
- ADD (op 0), A=0x12345678, B=0x11111111 → after 9 cycles `rsp_result=0x23456789`, `rsp_carry=0`, `rsp_err=0`; exactly 4 `alu_ld`, 1 `alu_opld`, 2 `alu_exe` pulses.
- ADD, A=0xFFFFFFFF, B=0x00000001 → `rsp_result=0x00000000`, `rsp_carry=1`. Then SUBI (op 10), A=5, B=3 → `rsp_result=0x00000002`, `rsp_carry=0`.
- Illegal op 20 → `rsp_valid` in cycle 1, `rsp_err=1`, `rsp_result=0`, zero ALU strobes; the next ADD (1+2) returns 3.
- Hold `rsp_ready=0` for 5 cycles after a NOT (op 5), A=0x0000FFFF → `rsp_result=0xFFFF0000` stable throughout, `req_ready=0`, no strobes; completes on the `rsp_ready` edge.
- Assert `rst` for 1 cycle after LOAD1 (2 `ld` pulses issued) → 2 FLUSH `alu_ld` pulses with zero data, then IDLE. A following XOR (op 4), A=0xF0F0F0F0, B=0xFFFF0000 returns 0x0F0FF0F0.
- `req_valid` held high continuously → `req_ready` pulses once per 10 cycles; no request is accepted while busy.
